byte_path_arbiter: RTL and testbench
====================================

BYTE_PATH_ARBITER -- requirements
Module: byte_path_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, meaning the byte-path data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum beats per grant (1..15).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req  input  NREQ  per-requester valid; bit i means requester i offers a byte.
REQ-007 SHALL have port din  input  NREQ*W  requester data; requester i occupies bits [i*W +: W].
REQ-008 SHALL have port ack  output  NREQ  per-requester ready; a beat transfers when req[i] && ack[i].
REQ-009 SHALL have port dout  output  W  registered output byte.
REQ-010 SHALL have port dvalid  output  1  dout holds a valid byte.
REQ-011 SHALL have port dready  input  1  the downstream accepts dout when dvalid && dready.
REQ-012 SHALL have port src  output  clog2(NREQ)  index of the requester that produced dout.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and GRANT, with registers owner, ptr and beat count cnt.
REQ-014 In IDLE, when req is nonzero, SHALL select the first set req bit at or after ptr (round-robin, wrapping NREQ-1 -> 0).
REQ-015 SHALL latch the selected index into owner, clear cnt and enter GRANT on the next edge; arbitration latency is 1 cycle, and ack is all-zero in IDLE.
REQ-016 In GRANT, ack[owner] SHALL equal (!dvalid || dready); all other ack bits SHALL be 0.
REQ-017 On a transfer (req[owner] && ack[owner]), SHALL load dout<=din[owner], src<=owner and dvalid<=1, and SHALL increment cnt.
REQ-018 SHALL leave GRANT for IDLE, with ptr<=owner+1 mod NREQ, when the transfer that makes cnt equal MAX_BURST occurs.
REQ-019 SHALL also leave GRANT for IDLE, with ptr<=owner+1 mod NREQ, when req[owner] is 0 in a GRANT cycle.
REQ-020 SHALL clear dvalid when dvalid && dready and no transfer occurs in the same cycle; a simultaneous drain and transfer SHALL keep dvalid=1 with the new byte.
REQ-021 SHALL hold dout and src stable while dvalid && !dready.
REQ-022 SHALL keep ack[owner]=0 while the output is stalled (dvalid && !dready), without counting a beat or releasing the grant.
REQ-023 A requester SHALL NOT be granted twice in a row while any other req bit was set at arbitration time.
REQ-024 Transfers SHALL be lossless and in order per requester; the requester's din is not inspected beyond the selected lane.

Reset
REQ-025 On rst_n low, SHALL asynchronously set: state=IDLE, owner=0, ptr=0, cnt=0, dvalid=0, dout=0, src=0, ack=0.
REQ-026 A reset asserted mid-burst SHALL discard the held byte; after release, the first arbitration SHALL start from ptr=0.
REQ-027 SHALL deassert reset with no output glitch; ack SHALL stay 0 until the first GRANT cycle.

Structure
REQ-028 SHALL place the state encoding (IDLE, GRANT) and a helper constant for the src width in the shared package byte_path_pkg.
REQ-029 SHALL implement round-robin selection as sub-module rr_pick (inputs: req, ptr; outputs: hit, index), purely combinational.
REQ-030 SHALL keep the datapath to a single output register stage with no FIFO.

Verification
REQ-031 The bench SHALL check: single requester 2 with req held, dready=1, MAX_BURST=4 -> 4 bytes with src=2, then 1 IDLE cycle, then a re-grant to 2.
REQ-032 The bench SHALL check: req=4'b1111 held, dready=1 -> owners in order 0,1,2,3,0, with 4 beats each and 1 IDLE cycle between grants.
REQ-033 The bench SHALL check: the owner drops req after 2 beats -> the grant releases, and the next owner is the next set bit after the old owner.
REQ-034 The bench SHALL check: dready=0 for 5 cycles mid-burst with dout=8'hA5 -> dout/src stable, ack=0, cnt unchanged; the burst resumes after dready=1.
REQ-035 The bench SHALL check: rst_n pulsed low during the third beat of requester 1 -> dvalid=0 immediately, and requester 0 is granted first after release with req=4'b0011.
REQ-036 The bench SHALL check: simultaneous drain and transfer every cycle with bytes 8'h01..8'h04 -> dvalid stays 1 and the sequence 01,02,03,04 is accepted without loss.

Source files
------------

// File: rtl/byte_path_pkg.sv
// rtl/byte_path_pkg.sv - shared constants for the byte path arbiter
//
// Purpose: FSM state encoding, beat counter width and a helper that sizes
//          requester-index fields from the requester count.
// Ports:   none (package).

package byte_path_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Beat counter width; bursts are at most 15 beats long.
  localparam int BEAT_W = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: finds the first set request bit at or after ptr, wrapping from
//          NREQ-1 back to 0.
// Ports:   req   - request vector, one bit per requester
//          ptr   - index where the search starts
//          hit   - at least one request bit is set
//          index - chosen requester (0 when hit is low)

module rr_pick #(
  parameter int NREQ = 4,
  parameter int SW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic            hit,
  output logic [SW-1:0]   index
);

  logic [SW-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest set bit is the
  // last one written and therefore wins.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = SW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        hit   = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/byte_path_arbiter.sv
// rtl/byte_path_arbiter.sv - round-robin burst arbiter onto one byte path
//
// Purpose: grants one requester at a time for up to MAX_BURST beats and
//          forwards its bytes through a single output register.
// Ports:   clk, rst_n       - clock, asynchronous active-low reset
//          req, din, ack    - per-requester valid, packed data, ready
//          dout, dvalid     - registered output byte and its valid
//          dready           - downstream ready
//          src              - requester index that produced dout

module byte_path_arbiter
  import byte_path_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*W-1:0]            din,
  output logic [NREQ-1:0]              ack,
  output logic [W-1:0]                 dout,
  output logic                         dvalid,
  input  logic                         dready,
  output logic [src_width(NREQ)-1:0]   src
);

  localparam int SW = src_width(NREQ);

  logic [0:0]        state;
  logic [SW-1:0]     owner;
  logic [SW-1:0]     ptr;
  logic [SW-1:0]     next_ptr;
  logic [BEAT_W-1:0] cnt;
  logic              pick_hit;
  logic [SW-1:0]     pick_idx;
  logic              out_free;
  logic              xfer;
  logic              last_beat;

  rr_pick #(
    .NREQ (NREQ),
    .SW   (SW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .hit   (pick_hit),
    .index (pick_idx)
  );

  // The output register can take a byte when empty or draining this cycle.
  assign out_free  = !dvalid || dready;
  assign xfer      = (state == ST_GRANT) && req[owner] && out_free;
  assign last_beat = (cnt == BEAT_W'(MAX_BURST - 1));
  assign next_ptr  = (owner == SW'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    ack = '0;
    if (state == ST_GRANT) begin
      ack[owner] = out_free;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_hit) begin
            owner <= pick_idx;
            cnt   <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Moving ptr past the owner keeps it from winning back-to-back
          // grants while anyone else is waiting.
          if (!req[owner]) begin
            state <= ST_IDLE;
            ptr   <= next_ptr;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              state <= ST_IDLE;
              ptr   <= next_ptr;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvalid <= 1'b0;
      dout   <= '0;
      src    <= '0;
    end else if (xfer) begin
      dout   <= din[owner*W +: W];
      src    <= owner;
      dvalid <= 1'b1;
    end else if (dvalid && dready) begin
      dvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_path_arbiter.sv
// tb/tb_byte_path_arbiter.sv - directed self-checking bench for byte_path_arbiter

module tb_byte_path_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic [7:0]  dout;
  logic        dvalid;
  logic        dready;
  logic [1:0]  src;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic        dready;
    logic [3:0]  ack;
    logic        dvalid;
    logic [7:0]  dout;
    logic [1:0]  src;
  } vec_t;

  vec_t tab [9];

  byte_path_arbiter #(
    .NREQ      (4),
    .W         (8),
    .MAX_BURST (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .din    (din),
    .ack    (ack),
    .dout   (dout),
    .dvalid (dvalid),
    .dready (dready),
    .src    (src)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    din    = '0;
    dready = 1'b1;
    step();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dvalid", 32'(dvalid), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_src", 32'(src), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Requester 2 alone: 4 beats, one IDLE cycle, re-grant, then release on req drop.
    tab[0] = '{4'b0100, 32'h0010_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    tab[1] = '{4'b0100, 32'h0011_0000, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0};
    tab[2] = '{4'b0100, 32'h0012_0000, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd2};
    tab[3] = '{4'b0100, 32'h0013_0000, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tab[4] = '{4'b0100, 32'h0014_0000, 1'b1, 4'b0100, 1'b1, 8'h13, 2'd2};
    tab[5] = '{4'b0100, 32'h0015_0000, 1'b1, 4'b0000, 1'b1, 8'h14, 2'd2};
    tab[6] = '{4'b0100, 32'h0016_0000, 1'b1, 4'b0100, 1'b0, 8'h14, 2'd2};
    tab[7] = '{4'b0000, 32'h0017_0000, 1'b1, 4'b0100, 1'b1, 8'h16, 2'd2};
    tab[8] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h16, 2'd2};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      req    = tab[i].req;
      din    = tab[i].din;
      dready = tab[i].dready;
      #1;
      check($sformatf("single_ack[%0d]", i), 32'(ack), 32'(tab[i].ack));
      check($sformatf("single_dvalid[%0d]", i), 32'(dvalid), 32'(tab[i].dvalid));
      check($sformatf("single_dout[%0d]", i), 32'(dout), 32'(tab[i].dout));
      check($sformatf("single_src[%0d]", i), 32'(src), 32'(tab[i].src));
      step();
    end

    // All four requesting: owners 0,1,2,3,0 with 4 beats each.
    do_reset();
    req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      int o;
      o = g % 4;
      #1;
      check($sformatf("rr_idle_ack[%0d]", g), 32'(ack), 32'h0);
      step();
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < 4; i++) din[i*8 +: 8] = {4'(i), 4'(b)};
        #1;
        check($sformatf("rr_ack[%0d.%0d]", g, b), 32'(ack), 32'(4'b0001 << o));
        step();
        check($sformatf("rr_dout[%0d.%0d]", g, b), 32'(dout), 32'({4'(o), 4'(b)}));
        check($sformatf("rr_src[%0d.%0d]", g, b), 32'(src), 32'(o));
        check($sformatf("rr_dvalid[%0d.%0d]", g, b), 32'(dvalid), 32'h1);
      end
    end

    // Owner 0 drops req after 2 beats; next owner is 3 (next set bit after 0).
    do_reset();
    req = 4'b1001;
    din = 32'hD3C2_B1A0;
    #1;
    check("drop_idle_ack", 32'(ack), 32'h0);
    step();
    check("drop_ack_b0", 32'(ack), 32'h1);
    step();
    check("drop_dout_b0", 32'(dout), 32'hA0);
    check("drop_ack_b1", 32'(ack), 32'h1);
    step();
    req = 4'b1000;
    step();
    check("drop_release_ack", 32'(ack), 32'h0);
    check("drop_release_dvalid", 32'(dvalid), 32'h0);
    step();
    check("drop_next_ack", 32'(ack), 32'b1000);
    step();
    check("drop_next_dout", 32'(dout), 32'hD3);
    check("drop_next_src", 32'(src), 32'h3);

    // Output stall for 5 cycles holding A5 mid-burst, then resume.
    do_reset();
    req = 4'b0010;
    din = 32'h0000_5A00;
    #1;
    check("stall_idle_ack", 32'(ack), 32'h0);
    step();
    check("stall_ack_b0", 32'(ack), 32'b0010);
    step();
    din = 32'h0000_A500;
    check("stall_ack_b1", 32'(ack), 32'b0010);
    step();
    din    = 32'h0000_0100;
    dready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check($sformatf("stall_ack[%0d]", s), 32'(ack), 32'h0);
      check($sformatf("stall_dvalid[%0d]", s), 32'(dvalid), 32'h1);
      check($sformatf("stall_dout[%0d]", s), 32'(dout), 32'hA5);
      check($sformatf("stall_src[%0d]", s), 32'(src), 32'h1);
      step();
    end
    dready = 1'b1;
    #1;
    check("resume_ack_b2", 32'(ack), 32'b0010);
    step();
    check("resume_dout_b2", 32'(dout), 32'h01);
    din = 32'h0000_0200;
    #1;
    check("resume_ack_b3", 32'(ack), 32'b0010);
    step();
    check("resume_dout_b3", 32'(dout), 32'h02);
    check("resume_end_ack", 32'(ack), 32'h0);

    // Reset during the third beat of requester 1, then req=0011 grants 0 first.
    do_reset();
    req = 4'b0010;
    din = 32'h0000_3344;
    step();
    step();
    step();
    #1;
    check("midrst_ack_b2", 32'(ack), 32'b0010);
    check("midrst_dvalid_pre", 32'(dvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_dvalid", 32'(dvalid), 32'h0);
    check("midrst_ack", 32'(ack), 32'h0);
    check("midrst_dout", 32'(dout), 32'h0);
    req = 4'b0011;
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst_release_ack", 32'(ack), 32'h0);
    step();
    check("midrst_grant_ack", 32'(ack), 32'b0001);
    step();
    check("midrst_grant_src", 32'(src), 32'h0);
    check("midrst_grant_dout", 32'(dout), 32'h44);

    // Drain and transfer in the same cycle for bytes 01..04.
    do_reset();
    req = 4'b0001;
    din = 32'h0000_0001;
    #1;
    check("flow_idle_ack", 32'(ack), 32'h0);
    step();
    for (int b = 1; b <= 4; b++) begin
      din = 32'(b);
      #1;
      check($sformatf("flow_ack[%0d]", b), 32'(ack), 32'h1);
      step();
      check($sformatf("flow_dvalid[%0d]", b), 32'(dvalid), 32'h1);
      check($sformatf("flow_dout[%0d]", b), 32'(dout), 32'(b));
    end
    req = 4'b0000;
    #1;
    check("flow_tail_dvalid", 32'(dvalid), 32'h1);
    check("flow_tail_dout", 32'(dout), 32'h04);
    step();
    check("flow_drained", 32'(dvalid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
